// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_arbiter_pkg: shared types and constants for the data-memory arbiter
package data_memory_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_STALL, ARB_DONE} arb_state_e;
  localparam int STALL_CNT_W_DEF = 8;
  localparam logic [STALL_CNT_W_DEF-1:0] STALL_SAT = '1;
endpackage

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares the data RAM between the CPU core (fixed priority) and a host port,
// forcing a one-cycle core stall when the host has waited STARVE_LIMIT busy cycles.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int D_ADDR_W     = 12,
  parameter int STARVE_LIMIT = 15,
  parameter int STARVE_CNT_W = 4,
  parameter int STALL_CNT_W  = STALL_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [D_ADDR_W-1:0]    core_addr,
  input  logic [DATA_W-1:0]      core_wdata,
  input  logic                   core_we,
  input  logic                   core_re,
  output logic [DATA_W-1:0]      core_rdata,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [D_ADDR_W-1:0]    host_addr,
  input  logic [DATA_W-1:0]      host_wdata,
  output logic                   host_ack,
  output logic [DATA_W-1:0]      host_rdata,
  output logic                   host_busy,
  output logic                   core_stall,
  output logic                   grant_host,
  output logic [STALL_CNT_W-1:0] stall_events,
  output logic [D_ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_we,
  input  logic [DATA_W-1:0]      mem_rdata
);
  arb_state_e              state_q, state_d;
  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;
  logic [D_ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic                    we_q, we_d;
  logic [STALL_CNT_W-1:0]  stall_q, stall_d;
  logic                    core_busy;
  assign core_busy    = core_we | core_re;
  assign grant_host   = (state_q == ARB_WAIT && !core_busy) || state_q == ARB_STALL;
  assign core_stall   = state_q == ARB_STALL;
  assign host_ack     = state_q == ARB_DONE;
  assign host_busy    = state_q != ARB_IDLE;
  assign host_rdata   = rdata_q;
  assign stall_events = stall_q;
  assign core_rdata   = mem_rdata;
  assign mem_addr     = grant_host ? addr_q : core_addr;
  assign mem_wdata    = grant_host ? wdata_q : core_wdata;
  // Gating with reset_n keeps a stray core write from reaching the RAM while held in reset.
  assign mem_we       = reset_n & (grant_host ? we_q : core_we);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    stall_d = stall_q;
    rdata_d = (grant_host && !we_q) ? mem_rdata : rdata_q;
    case (state_q)
      ARB_IDLE: if (host_req) begin
        state_d = ARB_WAIT;
        cnt_d   = '0;
        addr_d  = host_addr;
        wdata_d = host_wdata;
        we_d    = host_we;
      end
      ARB_WAIT: begin
        state_d = !core_busy ? ARB_DONE
                : cnt_q == STARVE_CNT_W'(STARVE_LIMIT - 1) ? ARB_STALL : ARB_WAIT;
        cnt_d   = (core_busy && state_d == ARB_WAIT) ? cnt_q + STARVE_CNT_W'(1) : cnt_q;
      end
      ARB_STALL: begin
        state_d = ARB_DONE;
        stall_d = &stall_q ? stall_q : stall_q + STALL_CNT_W'(1);
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed bench for data_memory_arbiter with a behavioural RAM.
module tb_data_memory_arbiter;
  logic        clk, reset_n;
  logic [11:0] core_addr, host_addr, mem_addr;
  logic [7:0]  core_wdata, core_rdata, host_wdata, host_rdata, mem_wdata, mem_rdata;
  logic        core_we, core_re, host_req, host_we, host_ack, host_busy;
  logic        core_stall, grant_host, mem_we;
  logic [7:0]  stall_events;
  logic [7:0]  ram [4096];
  int tests = 0, fails = 0, bad, acks, n, lat0, timeouts, dbl = 0;
  logic prev_stall = 1'b0;

  data_memory_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we), .core_re(core_re),
    .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_busy(host_busy),
    .core_stall(core_stall), .grant_host(grant_host), .stall_events(stall_events),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  always @(negedge clk) begin
    if (core_stall && prev_stall) dbl++;
    prev_stall = core_stall;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_go(input logic we, input logic [11:0] a, input logic [7:0] d);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
  endtask

  initial begin
    reset_n = 1'b1; core_addr = '0; core_wdata = '0; core_we = 1'b0; core_re = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h300] = 8'hC3;
    #1 reset_n = 1'b0; core_we = 1'b1; core_addr = 12'h007;
    #2;
    chk("rst_ack", host_ack, 0);
    chk("rst_busy", host_busy, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_grant", grant_host, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_events", stall_events, 0);
    chk("rst_mem_we", mem_we, 0);
    tick(); tick();
    core_we = 1'b0; reset_n = 1'b1;
    tick();
    // idle core: host write then read back
    host_go(1'b1, 12'h123, 8'h5A);
    tick(); #1;
    chk("w_grant", grant_host, 1);
    chk("w_mem_we", mem_we, 1);
    chk("w_mem_addr", mem_addr, 12'h123);
    chk("w_mem_wdata", mem_wdata, 8'h5A);
    chk("w_stall", core_stall, 0);
    chk("w_busy", host_busy, 1);
    chk("w_ack_early", host_ack, 0);
    tick(); #1;
    chk("w_ack", host_ack, 1);
    chk("w_grant_done", grant_host, 0);
    chk("w_ram", ram[12'h123], 8'h5A);
    host_req = 1'b0;
    tick(); #1;
    chk("w_idle_busy", host_busy, 0);
    chk("w_idle_ack", host_ack, 0);
    host_go(1'b0, 12'h123, 8'hFF);
    tick(); #1;
    chk("r_grant", grant_host, 1);
    chk("r_mem_we", mem_we, 0);
    tick(); #1;
    chk("r_ack", host_ack, 1);
    chk("r_rdata", host_rdata, 8'h5A);
    host_req = 1'b0;
    tick();
    // always-busy core: forced stall
    core_re = 1'b1; core_addr = 12'h200;
    host_go(1'b0, 12'h300, 8'h00);
    tick();
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      #1 if (grant_host || core_stall || !host_busy) bad++;
      tick();
    end
    chk("s_wait_cycles", bad, 0);
    #1;
    chk("s_stall", core_stall, 1);
    chk("s_grant", grant_host, 1);
    chk("s_mem_addr", mem_addr, 12'h300);
    tick(); #1;
    chk("s_ack", host_ack, 1);
    chk("s_stall_done", core_stall, 0);
    chk("s_events", stall_events, 1);
    chk("s_rdata", host_rdata, 8'hC3);
    host_req = 1'b0; core_re = 1'b0;
    tick();
    // core busy three cycles, then idle
    host_go(1'b1, 12'h040, 8'h77);
    core_re = 1'b1; core_addr = 12'h000;
    tick(); #1;
    chk("b_grant1", grant_host, 0);
    tick();
    core_re = 1'b0; core_we = 1'b1; core_addr = 12'h010; core_wdata = 8'h11;
    #1;
    chk("b_core_we", mem_we, 1);
    chk("b_core_addr", mem_addr, 12'h010);
    chk("b_grant2", grant_host, 0);
    tick();
    core_we = 1'b0; core_re = 1'b1; core_addr = 12'h000;
    tick();
    core_re = 1'b0;
    #1;
    chk("b_grant4", grant_host, 1);
    chk("b_stall4", core_stall, 0);
    chk("b_addr4", mem_addr, 12'h040);
    chk("b_wdata4", mem_wdata, 8'h77);
    tick(); #1;
    chk("b_ack", host_ack, 1);
    chk("b_ram_core", ram[12'h010], 8'h11);
    chk("b_ram_host", ram[12'h040], 8'h77);
    chk("b_events", stall_events, 1);
    host_req = 1'b0;
    tick();
    // core write presented in the stall cycle is gated
    host_go(1'b1, 12'h050, 8'h99);
    core_re = 1'b1; core_addr = 12'h000;
    tick();
    for (int i = 0; i < 15; i++) tick();
    core_we = 1'b1; core_addr = 12'h020; core_wdata = 8'hEE;
    #1;
    chk("g_stall", core_stall, 1);
    chk("g_mem_addr", mem_addr, 12'h050);
    chk("g_mem_wdata", mem_wdata, 8'h99);
    tick(); #1;
    chk("g_ack", host_ack, 1);
    chk("g_ram_core_gated", ram[12'h020], 8'h00);
    chk("g_ram_host", ram[12'h050], 8'h99);
    chk("g_core_we", mem_we, 1);
    chk("g_core_addr", mem_addr, 12'h020);
    host_req = 1'b0;
    tick(); #1;
    chk("g_ram_core_retry", ram[12'h020], 8'hEE);
    chk("g_events", stall_events, 2);
    core_we = 1'b0; core_re = 1'b0;
    // reset during WAIT drops the request
    host_go(1'b1, 12'h060, 8'hAB);
    core_re = 1'b1; core_we = 1'b1; core_addr = 12'h070; core_wdata = 8'h55;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("x_busy", host_busy, 0);
    chk("x_grant", grant_host, 0);
    chk("x_stall", core_stall, 0);
    chk("x_ack", host_ack, 0);
    chk("x_mem_we", mem_we, 0);
    chk("x_rdata", host_rdata, 0);
    chk("x_events", stall_events, 0);
    host_req = 1'b0; core_re = 1'b0; core_we = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1 if (host_ack) acks++;
    end
    chk("x_no_ack", acks, 0);
    chk("x_ram_untouched", ram[12'h060], 8'h00);
    host_go(1'b1, 12'h060, 8'hAB);
    tick(); #1;
    chk("x_re_grant", grant_host, 1);
    tick(); #1;
    chk("x_re_ack", host_ack, 1);
    host_req = 1'b0;
    tick(); #1;
    chk("x_re_ram", ram[12'h060], 8'hAB);
    // saturation over 300 forced stalls
    core_re = 1'b1; core_addr = 12'h000;
    timeouts = 0; lat0 = 0;
    for (int k = 0; k < 300; k++) begin
      host_go(1'b0, 12'h123, 8'h00);
      n = 0;
      do begin
        tick(); #1;
        n++;
      end while (!host_ack && n < 40);
      if (!host_ack) timeouts++;
      if (k == 0) lat0 = n;
      host_req = 1'b0;
      tick();
    end
    chk("sat_timeouts", timeouts, 0);
    chk("sat_latency", lat0, 17);
    chk("sat_events", stall_events, 8'd255);
    chk("sat_rdata", host_rdata, 8'h5A);
    chk("stall_back_to_back", dbl, 0);
    core_re = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port data memory between the Turtle CPU core and a host/debug port (loader, probe).
- The core has no stall input, so the core has fixed priority. The host is served in cycles when the core does not touch memory.
- If the host waits too long, the arbiter asserts core_stall for exactly one cycle. Top-level logic uses core_stall as the core clock-enable, and the host access completes during that cycle.
- Sits between turtle_cpu_core's data-memory interface and the data RAM.

Parameters:
DATA_W, 8, data width
D_ADDR_W, 12, data address width
STARVE_LIMIT, 15, busy WAIT cycles tolerated before forcing a stall (legal range 1..2**STARVE_CNT_W-1)
STARVE_CNT_W, 4, starvation counter width
STALL_CNT_W, 8, width of saturating stall-event counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
core_addr  in  D_ADDR_W  core data address
core_wdata  in  DATA_W  core write data
core_we  in  1  core write request
core_re  in  1  core read request
core_rdata  out  DATA_W  read data to core (= mem_rdata)
host_req  in  1  host request, held high until host_ack
host_we  in  1  1=write, 0=read; sampled with host_req
host_addr  in  D_ADDR_W  host address; sampled with host_req
host_wdata  in  DATA_W  host write data; sampled with host_req
host_ack  out  1  one-cycle completion pulse
host_rdata  out  DATA_W  captured read data, valid when host_ack=1, held until next capture
host_busy  out  1  request accepted and not yet acked
core_stall  out  1  core clock-enable low request
grant_host  out  1  host owns memory this cycle
stall_events  out  STALL_CNT_W  saturating count of forced stalls
mem_addr  out  D_ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write enable; RAM writes synchronously
mem_rdata  in  DATA_W  RAM read data; combinational read

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE; counters=0.
  - host_ack=0, host_busy=0, core_stall=0, grant_host=0, host_rdata=0, stall_events=0.
  - mem_we forced 0 while reset_n low.
  - A request in flight is dropped with no ack; the host reissues it.
- core_busy = core_we | core_re. If both are high, it is treated as a write.
- Memory mux:
  - grant_host=0: mem_addr/mem_wdata come from core; mem_we=core_we.
  - grant_host=1: mem_addr/mem_wdata come from the latched host request; mem_we=latched host_we. Core writes are suppressed.
- FSM (Moore outputs):
  - IDLE: host_busy=0. If host_req=1, latch addr/we/wdata, clear cnt, go to WAIT.
  - WAIT: host_busy=1.
    - If core_busy=0: grant_host=1 (combinational); host access happens this cycle; go to DONE.
    - Else if cnt==STARVE_LIMIT-1: go to STALL.
    - Else cnt++.
  - STALL: core_stall=1, grant_host=1, host_busy=1. Host access happens this cycle; core writes are gated; stall_events++ (saturating at all-ones); go to DONE.
  - DONE: host_ack=1, host_busy=1. host_req is ignored this cycle. Go to IDLE.
- Read capture: at the end of the granted cycle, host_rdata <= mem_rdata. A host write leaves host_rdata unchanged.
- core_stall is high in at most one cycle per request, and is never high in two consecutive cycles.
- Latency, counted from the edge that samples host_req:
  - Idle core: access in the next cycle, host_ack 2 cycles after sampling.
  - Always-busy core: STARVE_LIMIT WAIT cycles, then STALL, then host_ack at STARVE_LIMIT+2.
- host_req still high in IDLE after DONE is a new request. The host must drop host_req on seeing host_ack.
- Host changes to addr/data/we after acceptance have no effect.

Decomposition:
- data_memory_arbiter_pkg holds:
  - arb_state_e {ARB_IDLE, ARB_WAIT, ARB_STALL, ARB_DONE}
  - localparam STALL_SAT (all-ones saturation value)
- No sub-module; FSM, counters and mux live in one module.

Test Plan:
- Core idle, host write 0x5A to 0x123: mem_we=1, mem_addr=0x123, grant_host=1 in cycle 1; host_ack in cycle 2; core_stall never high; a subsequent host read of 0x123 returns host_rdata=0x5A.
- Core core_re=1 continuously, STARVE_LIMIT=15, host read: 15 WAIT cycles, then core_stall=1 for one cycle with grant_host=1; host_ack at cycle 17; stall_events=1.
- Core busy 3 cycles then idle, host write: access in cycle 4 with no stall; core write at addr 0x010 in cycle 2 lands in RAM unchanged.
- core_we=1 to 0x020 during STALL cycle: RAM[0x020] unchanged, host write lands; core re-presents the write after the stall and it lands.
- Reset asserted while in WAIT: all outputs 0 immediately, state IDLE; no host_ack afterwards; reissued request completes normally.
- 300 forced stalls: stall_events saturates at 255.
